// File: rtl/n64_pkg.sv
// Shared Joybus timing constants, host state encoding, button bit positions
// and the 7-segment decoder used by the optional debug display.
package n64_pkg;

  localparam int US_CLK   = 25;
  localparam int T_LOW1   = US_CLK;
  localparam int T_SAMPLE = 2 * US_CLK;
  localparam int T_LOW0   = 3 * US_CLK;
  localparam int T_BIT    = 4 * US_CLK;

  localparam logic [7:0] CMD_POLL = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_DONE = 2'd3
  } host_state_e;

  localparam int BTN_A = 31;
  localparam int BTN_B = 30;
  localparam int BTN_Z = 29;
  localparam int BTN_S = 28;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/n64_serial_top_joybus_host.sv
// Joybus host engine: sends the poll command, then receives and frames the
// 32-bit pad response. The line input must already be synchronised.
module joybus_host
  import n64_pkg::*;
#(
  parameter int RX_TIMEOUT = 2_500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        jb_sync_i,
  output logic        drive_low,
  output logic        tx_done,
  output logic        rx_done,
  output logic [31:0] resp,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_TX   = ST_TX;
  localparam logic [1:0] S_RX   = ST_RX;
  localparam logic [1:0] S_DONE = ST_DONE;
  localparam int IW = $clog2(RX_TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [6:0]    cell_q, cell_d;
  logic [5:0]    bit_q, bit_d;
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic [31:0]   rx_sr_q, rx_sr_d;
  logic [31:0]   resp_q, resp_d;
  logic [6:0]    samp_q, samp_d;
  logic          arm_q, arm_d;
  logic          stop_q, stop_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          prev_q;
  logic          tx_done_q, tx_done_d;
  logic          rx_done_q, rx_done_d;
  logic          fall_s, rise_s;
  logic [6:0]    low_len_s;

  assign fall_s    = prev_q & ~jb_sync_i;
  assign rise_s    = ~prev_q & jb_sync_i;
  // The stop bit uses the short low phase, same as a data '1'.
  assign low_len_s = ((bit_q == 6'd8) || tx_sr_q[7]) ? 7'(T_LOW1) : 7'(T_LOW0);

  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    resp_d    = resp_q;
    samp_d    = samp_q;
    arm_d     = arm_q;
    stop_d    = stop_q;
    idle_d    = idle_q;
    tx_done_d = 1'b0;
    rx_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_TX;
          cell_d  = 7'd0;
          bit_d   = 6'd0;
          tx_sr_d = CMD_POLL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (bit_q == 6'd8) begin
          if (cell_q == 7'(T_LOW1 - 1)) begin
            state_d   = S_RX;
            tx_done_d = 1'b1;
            bit_d     = 6'd0;
            arm_d     = 1'b0;
            stop_d    = 1'b0;
            idle_d    = {IW{1'b0}};
          end else begin
            cell_d = cell_q + 7'd1;
          end
        end else if (cell_q == 7'(T_BIT - 1)) begin
          cell_d  = 7'd0;
          bit_d   = bit_q + 6'd1;
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end else begin
          cell_d = cell_q + 7'd1;
        end
      end
      S_RX: begin
        idle_d = jb_sync_i ? (idle_q + IW'(1)) : {IW{1'b0}};
        // Each falling edge arms a sampler that reads the line mid-cell.
        if (arm_q && (samp_q == 7'(T_SAMPLE))) begin
          arm_d   = 1'b0;
          rx_sr_d = {rx_sr_q[30:0], jb_sync_i};
          bit_d   = bit_q + 6'd1;
        end else if (arm_q) begin
          samp_d = samp_q + 7'd1;
        end else if (fall_s && (bit_q == 6'd32)) begin
          stop_d = 1'b1;
        end else if (fall_s) begin
          arm_d  = 1'b1;
          samp_d = 7'd1;
        end else begin
          arm_d = 1'b0;
        end
        if (stop_q && rise_s) begin
          rx_done_d = 1'b1;
          resp_d    = rx_sr_q;
          state_d   = S_DONE;
        end else if (jb_sync_i && (idle_q == IW'(RX_TIMEOUT - 1))) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RX;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cell_q    <= 7'd0;
      bit_q     <= 6'd0;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 32'h0000_0000;
      resp_q    <= 32'h0000_0000;
      samp_q    <= 7'd0;
      arm_q     <= 1'b0;
      stop_q    <= 1'b0;
      idle_q    <= {IW{1'b0}};
      prev_q    <= 1'b1;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      resp_q    <= resp_d;
      samp_q    <= samp_d;
      arm_q     <= arm_d;
      stop_q    <= stop_d;
      idle_q    <= idle_d;
      prev_q    <= jb_sync_i;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
    end
  end

  assign drive_low = (state_q == S_TX) && (cell_q < low_len_s);
  assign tx_done   = tx_done_q;
  assign rx_done   = rx_done_q;
  assign resp      = resp_q;
  assign state_o   = state_q;

endmodule

// File: rtl/n64_serial_top.sv
// N64 pad poller: periodic Joybus poll, button latch and open-drain line driver.
// Optional 7-segment debug display of resp[31:16] is built when DBG_DISPLAY_EN is defined.
module n64_serial_top
  import n64_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int POLL_CYCLES = 416_667,
  parameter int RX_TIMEOUT  = 2_500
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        JB,
  output logic       TX,
  output logic       btn_A,
  output logic       btn_B,
  output logic       btn_Z,
  output logic       btn_S,
  output logic [3:0] dbg,
  output logic [3:0] DBG_dig,
  output logic [7:0] DBG_seg,
  output logic       DBG_count_high
);

  localparam int PW = $clog2(POLL_CYCLES);

  logic [PW-1:0] poll_q;
  logic          jb_meta_q, jb_sync_q;
  logic          jb_oe_q;
  logic [31:0]   status_q;
  logic [3:0]    dbg_q;
  logic          cnt_high_q;
  logic          start_s, drive_low_s, tx_done_s, rx_done_s;
  logic [31:0]   resp_s;
  logic [1:0]    host_state_s;
  logic          unused_s;

  assign start_s = (poll_q == PW'(POLL_CYCLES - 1));

  joybus_host #(
    .RX_TIMEOUT(RX_TIMEOUT)
  ) iJB_HOST (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start_s),
    .jb_sync_i(jb_sync_q),
    .drive_low(drive_low_s),
    .tx_done  (tx_done_s),
    .rx_done  (rx_done_s),
    .resp     (resp_s),
    .state_o  (host_state_s)
  );

  // Free-running poll timer; a start landing while a frame is busy is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      poll_q     <= {PW{1'b0}};
      jb_meta_q  <= 1'b1;
      jb_sync_q  <= 1'b1;
      jb_oe_q    <= 1'b0;
      status_q   <= 32'h0000_0000;
      dbg_q      <= 4'h0;
      cnt_high_q <= 1'b0;
    end else begin
      poll_q     <= start_s ? {PW{1'b0}} : (poll_q + PW'(1));
      jb_meta_q  <= JB;
      jb_sync_q  <= jb_meta_q;
      jb_oe_q    <= drive_low_s;
      status_q   <= rx_done_s ? resp_s : status_q;
      dbg_q      <= {2'b00, host_state_s};
      cnt_high_q <= rx_done_s ? ~cnt_high_q : cnt_high_q;
    end
  end

  assign JB             = jb_oe_q ? 1'b0 : 1'bz;
  assign TX             = jb_oe_q;
  assign btn_A          = status_q[BTN_A];
  assign btn_B          = status_q[BTN_B];
  assign btn_Z          = status_q[BTN_Z];
  assign btn_S          = status_q[BTN_S];
  assign dbg            = dbg_q;
  assign DBG_count_high = cnt_high_q;
  assign unused_s       = ^{status_q[27:0], tx_done_s, 32'(CLK_HZ)};

`ifdef DBG_DISPLAY_EN
  localparam int SCAN_DIV = CLK_HZ / 4000;
  localparam int SW       = $clog2(SCAN_DIV);

  logic [SW-1:0] scan_q;
  logic [1:0]    digit_q;
  logic [3:0]    dig_q;
  logic [7:0]    seg_q;
  logic [3:0]    nib_s;

  always_comb begin
    nib_s = 4'h0;
    case (digit_q)
      2'd0:    nib_s = status_q[19:16];
      2'd1:    nib_s = status_q[23:20];
      2'd2:    nib_s = status_q[27:24];
      2'd3:    nib_s = status_q[31:28];
      default: nib_s = 4'h0;
    endcase
  end

  // Four digits each get a quarter of a 1 kHz refresh frame.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      scan_q  <= {SW{1'b0}};
      digit_q <= 2'd0;
      dig_q   <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_q  <= {SW{1'b0}};
        digit_q <= digit_q + 2'd1;
      end else begin
        scan_q  <= scan_q + SW'(1);
      end
      dig_q <= ~(4'b0001 << digit_q);
      seg_q <= {1'b1, hex_to_seg(nib_s)};
    end
  end

  assign DBG_dig = dig_q;
  assign DBG_seg = seg_q;
`else
  assign DBG_dig = 4'hF;
  assign DBG_seg = 8'hFF;
`endif

endmodule

// File: tb/tb_n64_serial_top.sv
// Bench for n64_serial_top: decodes the host poll frame, plays a pad device
// on the Joybus line and scores latched buttons against queued expectations.
module tb_n64_serial_top;

  localparam int POLL = 6000;
  localparam int RXTO = 2500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dev_low = 1'b0;
  wire        JB;
  logic       TX, btn_A, btn_B, btn_Z, btn_S, DBG_count_high;
  logic [3:0] dbg, DBG_dig;
  logic [7:0] DBG_seg;

  assign JB = dev_low ? 1'b0 : 1'bz;
  pullup (JB);

  always #5 clk = ~clk;

  n64_serial_top #(
    .CLK_HZ     (25_000_000),
    .POLL_CYCLES(POLL),
    .RX_TIMEOUT (RXTO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .JB            (JB),
    .TX            (TX),
    .btn_A         (btn_A),
    .btn_B         (btn_B),
    .btn_Z         (btn_Z),
    .btn_S         (btn_S),
    .dbg           (dbg),
    .DBG_dig       (DBG_dig),
    .DBG_seg       (DBG_seg),
    .DBG_count_high(DBG_count_high)
  );

  int         checks = 0;
  int         errors = 0;
  int         tx_done_cnt = 0;
  int         rx_done_cnt = 0;
  logic       cnt_model = 1'b0;
  logic [3:0] last_btn = 4'h0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (dut.iJB_HOST.tx_done === 1'b1) tx_done_cnt <= tx_done_cnt + 1;
  end

  // Scoreboard monitor: each rx_done pops one expectation.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (dut.iJB_HOST.rx_done === 1'b1) begin
        rx_done_cnt++;
        cnt_model = ~cnt_model;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_rx actual=rx_done required=none");
        end else begin
          e = exp_q.pop_front();
          check("sb_buttons", {28'h0, btn_A, btn_B, btn_Z, btn_S}, {28'h0, e});
          check("sb_count_high", {31'h0, DBG_count_high}, {31'h0, cnt_model});
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic host_frame(output logic [7:0] b, output int stop_len, output bit ok);
    int n;
    int len;
    ok = 1'b1;
    b = 8'h00;
    stop_len = 0;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (JB !== 1'b0 && n < 10000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 10000) begin
        ok = 1'b0;
        return;
      end
      len = 0;
      while (JB === 1'b0 && len < 200) begin
        @(negedge clk);
        len++;
      end
      if (i < 8) b = {b[6:0], (len < 50)};
      else stop_len = len;
    end
  endtask

  task automatic dev_send(input logic [31:0] v, input int nbits);
    logic bv;
    for (int i = 0; i < nbits; i++) begin
      bv = v[31-i];
      dev_low = 1'b1;
      repeat (bv ? 25 : 75) @(negedge clk);
      dev_low = 1'b0;
      repeat (bv ? 75 : 25) @(negedge clk);
    end
    if (nbits == 32) begin
      dev_low = 1'b1;
      repeat (25) @(negedge clk);
      dev_low = 1'b0;
    end
  endtask

  // mode 0: full response, 1: silent device, 2: 16 bits then reset
  task automatic poll(input logic [31:0] v, input int mode);
    logic [7:0] b;
    int sl;
    bit ok;
    int tdc;
    int rdc;
    tdc = tx_done_cnt;
    host_frame(b, sl, ok);
    check("frame_seen", {31'h0, ok}, 32'h1);
    check("tx_cmd", {24'h0, b}, 32'h01);
    check("tx_stop_len", sl, 32'd25);
    check("tx_done_pulse", tx_done_cnt - tdc, 32'd1);
    repeat (50) @(negedge clk);
    case (mode)
      0: begin
        exp_q.push_back(v[31:28]);
        dev_send(v, 32);
        last_btn = v[31:28];
        repeat (10) @(negedge clk);
      end
      1: begin
        rdc = rx_done_cnt;
        repeat (RXTO + 200) @(negedge clk);
        check("timeout_idle", {28'h0, dbg}, 32'h0);
        check("timeout_hold", {28'h0, btn_A, btn_B, btn_Z, btn_S}, {28'h0, last_btn});
        check("timeout_no_rx", rx_done_cnt, rdc);
      end
      default: begin
        dev_send(v, 16);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        cnt_model = 1'b0;
        last_btn = 4'h0;
        check("rst_jb_released", {31'h0, JB}, 32'h1);
        check("rst_tx", {31'h0, TX}, 32'h0);
        check("rst_buttons", {28'h0, btn_A, btn_B, btn_Z, btn_S}, 32'h0);
        check("rst_dbg", {28'h0, dbg}, 32'h0);
        rst_n = 1'b0;
      end
    endcase
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("reset_buttons", {28'h0, btn_A, btn_B, btn_Z, btn_S}, 32'h0);
    check("reset_dbg", {28'h0, dbg}, 32'h0);
    check("reset_tx", {31'h0, TX}, 32'h0);
    check("reset_jb", {31'h0, JB}, 32'h1);
    check("reset_dig", {28'h0, DBG_dig}, 32'hF);
    check("reset_seg", {24'h0, DBG_seg}, 32'hFF);
    check("reset_count_high", {31'h0, DBG_count_high}, 32'h0);
    check("reset_poll_timer", 32'(dut.poll_q), 32'h0);
    rst_n = 1'b0;

    poll(32'hA000_0000, 0);
    poll(32'h5ABC_1234, 0);
    poll(32'h3FFF_0001, 0);
    poll(32'hC123_4567, 0);
    poll(32'h0000_0000, 1);
    poll(32'h9F00_0000, 2);
    poll(32'hF000_0000, 0);
    poll(32'h0000_0000, 0);

    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
